// File: rtl/uart_tx_mod.sv
// uart_tx_mod: UART transmitter with a one-deep holding register. Data goes out MSB-first.
// Even parity bit after the data is added when UART_TX_PARITY_EN is defined.
module uart_tx_mod #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_bclk_en,
  input  logic [7:0] i_din,
  input  logic       i_d_vld,
  output logic       o_d_rdy,
  output logic       o_txd,
  output logic       o_busy,
  output logic       o_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  localparam logic StopLast = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  state_e      r_state;
  state_e      w_state_d;
  logic [7:0]  r_hold;
  logic        r_hold_full;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_d;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  w_bit_cnt_d;
  logic        r_stop_cnt;
  logic        w_stop_cnt_d;
  logic        r_txd;
  logic        w_txd_d;
  logic        r_done;
  logic        w_done_d;
  logic        w_accept;
  logic        w_last_stop;
  logic        w_load;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  assign w_accept    = i_d_vld && !r_hold_full;
  assign w_last_stop = (r_state == StStop) && (r_stop_cnt == StopLast);
  // Hold-to-shift transfer happens from IDLE or at the end of the final stop bit.
  assign w_load      = i_bclk_en && r_hold_full && ((r_state == StIdle) || w_last_stop);

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= 1'b0;
      r_txd       <= 1'b1;
      r_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_shift    <= w_shift_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_stop_cnt <= w_stop_cnt_d;
      r_txd      <= w_txd_d;
      r_done     <= w_done_d;
      if (w_accept) begin
        r_hold      <= i_din;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
`ifdef UART_TX_PARITY_EN
      if (w_load) begin
        r_parity <= ^r_hold;
      end
`endif
    end
  end

  // Next-state logic; nothing moves without a baud tick.
  always_comb begin
    w_state_d = r_state;
    if (i_bclk_en) begin
      case (r_state)
        StIdle:  if (r_hold_full) w_state_d = StStart;
        StStart: w_state_d = StData;
        StData: begin
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_d = StPar;
`else
            w_state_d = StStop;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        StPar:   w_state_d = StStop;
`endif
        StStop:  if (w_last_stop) w_state_d = r_hold_full ? StStart : StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Registered-output and datapath next values.
  always_comb begin
    w_txd_d      = r_txd;
    w_done_d     = 1'b0;
    w_shift_d    = r_shift;
    w_bit_cnt_d  = r_bit_cnt;
    w_stop_cnt_d = r_stop_cnt;
    if (i_bclk_en) begin
      case (r_state)
        StIdle: begin
          if (w_load) begin
            w_shift_d = r_hold;
            w_txd_d   = 1'b0;
          end
        end
        StStart: begin
          w_txd_d     = r_shift[7];
          w_bit_cnt_d = 3'd0;
        end
        StData: begin
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_txd_d = r_parity;
`else
            w_txd_d = 1'b1;
`endif
            w_stop_cnt_d = 1'b0;
          end else begin
            w_bit_cnt_d = r_bit_cnt + 3'd1;
            w_shift_d   = {r_shift[6:0], 1'b0};
            w_txd_d     = r_shift[6];
          end
        end
`ifdef UART_TX_PARITY_EN
        StPar: begin
          w_txd_d      = 1'b1;
          w_stop_cnt_d = 1'b0;
        end
`endif
        StStop: begin
          if (w_last_stop) begin
            w_done_d = 1'b1;
            w_txd_d  = !r_hold_full;
            if (w_load) begin
              w_shift_d = r_hold;
            end
          end else begin
            w_stop_cnt_d = 1'b1;
            w_txd_d      = 1'b1;
          end
        end
        default: w_txd_d = 1'b1;
      endcase
    end
  end

  assign o_d_rdy = !r_hold_full;
  assign o_txd   = r_txd;
  assign o_busy  = (r_state != StIdle);
  assign o_done  = r_done;

endmodule

// File: doc/uart_tx_mod.md
UART_TX_MOD -- requirements
Module: uart_tx_mod

Interface
REQ-001 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits per frame (legal values 1 or 2).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 bclk_en  input  1  baud tick, one clk cycle wide; each bit period is exactly one bclk_en tick.
REQ-005 din  input  8  byte to transmit.
REQ-006 d_vld  input  1  din valid; a byte is accepted on any clk edge where d_vld and d_rdy are both 1.
REQ-007 d_rdy  output  1  holding register empty; the block can accept a byte.
REQ-008 txd  output  1  serial line; idles high.
REQ-009 busy  output  1  high while a frame is being shifted (any state except IDLE).
REQ-010 done  output  1  one-clk pulse when the last stop bit of a frame completes.

Function
REQ-011 The block SHALL hold a one-deep holding register (hold, hold_full) and a separate shift register, so a second byte can be accepted while a frame is in flight.
REQ-012 d_rdy SHALL equal !hold_full; accepting a byte loads hold from din and sets hold_full on the same edge.
REQ-013 States: IDLE, START, DATA, PAR (PARITY_EN only), STOP; state advances only on clk edges with bclk_en=1.
REQ-014 IDLE: txd=1; on a bclk_en edge with hold_full=1 -> copy hold to shift register, clear hold_full, go to START.
REQ-015 START: txd=0 for one tick, then DATA with bit counter=0.
REQ-016 DATA: data goes out MSB-first (din[7] first, din[0] last), so the existing receiver, which shifts left into bit 0, reconstructs the byte unchanged; 8 ticks; after counter value 7 -> PAR if enabled, else STOP.
REQ-017 STOP: txd=1 for STOP_BITS ticks; on the final tick, done pulses for exactly one clk cycle.
REQ-018 After STOP, if hold_full=1 the block SHALL go directly to START (back-to-back frames, no idle tick), otherwise to IDLE.
REQ-019 Simultaneous accept and hold-to-shift transfer on the same edge: the new byte SHALL land in hold with hold_full=1, and the transferred byte SHALL be sent first; no byte is lost or duplicated.
REQ-020 d_vld while d_rdy=0 SHALL be ignored; hold is not overwritten.
REQ-021 din SHALL be sampled only at acceptance; later changes to din do not affect the frame.
REQ-022 txd SHALL be driven from a register (glitch-free).
REQ-023 bclk_en held low SHALL freeze the state machine, txd and the bit counter; acceptance into hold still works.

Reset
REQ-024 On a clk edge with rst_n=0: state=IDLE, txd=1, hold_full=0 (d_rdy=1), busy=0, done=0, counters=0, shift and hold registers=0.
REQ-025 A reset asserted mid-frame SHALL abort the frame: txd returns high on the reset edge and any pending held byte is discarded.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: when defined, a PAR state between DATA and STOP SHALL send one even-parity bit (XOR of the 8 data bits), giving 11 ticks per frame with STOP_BITS=1; when undefined, no PAR state exists and a frame is 10 ticks.

Verification
REQ-027 Reset then idle: rst_n low 2 cycles -> txd=1, d_rdy=1, busy=0, done=0.
REQ-028 Single byte 0xA5, bclk_en every 4 clks, no parity -> txd per tick 0,1,0,1,0,0,1,0,1,1; done pulses once; busy high for 10 ticks.
REQ-029 Back-to-back 0x3C then 0xFF, second offered while the first is in DATA -> d_rdy drops, then rises on transfer; frames are contiguous with no idle tick; the loopback receiver outputs 0x3C then 0xFF.
REQ-030 With UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 after data, 11-tick frame; byte 0x03 -> parity bit 0.
REQ-031 Reset mid-DATA of 0x55 with a byte pending in hold -> txd=1 and d_rdy=1 on the reset edge; no further frame is sent.
REQ-032 STOP_BITS=2, byte 0x00 -> txd 0, then eight 0s, then 1,1; done fires after the second stop tick.
